// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, msip bit, and registered
// MTIP/MSIP levels, behind a single-outstanding request/response port.
module machine_timer #(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        timer_irq,
    output logic        software_irq
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic [15:0] ps_count_reg;
    logic [63:0] mtime_reg;
    logic [63:0] mtimecmp_reg;
    logic        msip_reg;

    logic        tick;
    logic        accept;
    logic        wr;
    logic [2:0]  word;
    logic [31:0] mtime_lo_next;
    logic [31:0] mtime_hi_next;
    logic [31:0] cmp_lo_next;
    logic [31:0] cmp_hi_next;
    logic [31:0] rdata;
    logic        addr_unused;

    assign req_ready   = !rsp_valid || rsp_ready;
    assign accept      = req_valid && req_ready;
    assign wr          = accept && req_we;
    assign word        = req_addr[4:2];
    assign tick        = (ps_count_reg == PS_LAST);
    assign addr_unused = ^req_addr[1:0];

    // Byte-lane merge of write data into each 32-bit half.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign mtime_lo_next[8*gi +: 8] = req_wstrb[gi] ? req_wdata[8*gi +: 8] : mtime_reg[8*gi +: 8];
            assign mtime_hi_next[8*gi +: 8] = req_wstrb[gi] ? req_wdata[8*gi +: 8] : mtime_reg[32+8*gi +: 8];
            assign cmp_lo_next[8*gi +: 8]   = req_wstrb[gi] ? req_wdata[8*gi +: 8] : mtimecmp_reg[8*gi +: 8];
            assign cmp_hi_next[8*gi +: 8]   = req_wstrb[gi] ? req_wdata[8*gi +: 8] : mtimecmp_reg[32+8*gi +: 8];
        end
    endgenerate

    always_comb begin
        rdata = 32'h0;
        case (word)
            3'd0:    rdata = mtime_reg[31:0];
            3'd1:    rdata = mtime_reg[63:32];
            3'd2:    rdata = mtimecmp_reg[31:0];
            3'd3:    rdata = mtimecmp_reg[63:32];
            3'd4:    rdata = {31'h0, msip_reg};
            default: rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_count_reg <= '0;
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            msip_reg     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            timer_irq    <= 1'b0;
            software_irq <= 1'b0;
        end else begin
            ps_count_reg <= tick ? 16'd0 : ps_count_reg + 16'd1;

            // A write to either mtime half swallows a coincident tick.
            if (wr && word == 3'd0) begin
                mtime_reg <= {mtime_reg[63:32], mtime_lo_next};
            end else if (wr && word == 3'd1) begin
                mtime_reg <= {mtime_hi_next, mtime_reg[31:0]};
            end else if (tick) begin
                mtime_reg <= mtime_reg + 64'd1;
            end

            if (wr && word == 3'd2) begin
                mtimecmp_reg[31:0] <= cmp_lo_next;
            end
            if (wr && word == 3'd3) begin
                mtimecmp_reg[63:32] <= cmp_hi_next;
            end
            if (wr && word == 3'd4 && req_wstrb[0]) begin
                msip_reg <= req_wdata[0];
            end

            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= req_we ? 32'h0 : rdata;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            timer_irq    <= (mtime_reg >= mtimecmp_reg);
            software_irq <= msip_reg;
        end
    end

endmodule
